// File: rtl/axil_write_config_bridge_if.sv
// rtl/axil_write_config_bridge_if.sv - write_config_i: config write beat (addr/data/valid), no backpressure
//
// Ports (modports):
//   m : producer side, drives addr, data, valid
//   s : consumer side, samples addr, data, valid
interface write_config_i #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
    logic                 valid;

    modport m (output addr, output data, output valid);
    modport s (input  addr, input  data, input  valid);
endinterface

// File: rtl/axil_write_config_bridge.sv
// rtl/axil_write_config_bridge.sv - AXI4-Lite write slave that turns each write into one config beat
//
// Accepts one AXI4-Lite write at a time (AW and W in any order), emits a single
// out.valid pulse carrying (awaddr - ADDR_BASE, wdata), then answers on B.
//
// Parameters:
//   AXI_ADDR_BITS, AXIL_DATA_BITS : bus widths
//   ADDR_BASE                     : subtracted from awaddr (wraps, never an error)
//   OUT_REG                       : 1 = out fields registered, 0 = driven from capture registers
// Optional feature macro: AXIL_WSTRB_CHECK_EN
//   defined   -> partial-strobe writes are not forwarded and get SLVERR
//   undefined -> wstrb ignored, every write forwarded with OKAY
//
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   s_axil_aw*, s_axil_w*, s_axil_b*   : AXI4-Lite write address / data / response channels
//   out (write_config_i.m)             : forwarded config write, single-cycle valid
module axil_write_config_bridge #(
    parameter int                       AXI_ADDR_BITS  = 32,
    parameter int                       AXIL_DATA_BITS = 32,
    parameter logic [AXI_ADDR_BITS-1:0] ADDR_BASE      = '0,
    parameter bit                       OUT_REG        = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [AXI_ADDR_BITS-1:0]    s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,

    input  logic [AXIL_DATA_BITS-1:0]   s_axil_wdata,
    input  logic [AXIL_DATA_BITS/8-1:0] s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,

    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,

    write_config_i.m                    out
);
    typedef enum logic [1:0] {IDLE, EMIT, RESP} state_t;

    // Reset resynchroniser: asserts asynchronously, releases two clocks after rst_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    state_t                    state_q, state_d;
    logic                      aw_full_q, aw_full_d;
    logic                      w_full_q, w_full_d;
    logic [AXI_ADDR_BITS-1:0]  aw_addr_q, aw_addr_d;
    logic [AXIL_DATA_BITS-1:0] w_data_q, w_data_d;
    logic                      err_q, err_d;
    logic                      out_valid_q, out_valid_d;
    logic [AXI_ADDR_BITS-1:0]  out_addr_q, out_addr_d;
    logic [AXIL_DATA_BITS-1:0] out_data_q, out_data_d;
    logic                      resp_arm_q, resp_arm_d;

    logic strb_bad;
    logic aw_hs, w_hs, b_hs;

`ifdef AXIL_WSTRB_CHECK_EN
    assign strb_bad = (s_axil_wstrb != '1);
`else
    assign strb_bad = 1'b0;
    logic unused_wstrb;
    assign unused_wstrb = ^s_axil_wstrb;
`endif

    assign s_axil_awready = rst_int_n && (state_q == IDLE) && !aw_full_q;
    assign s_axil_wready  = rst_int_n && (state_q == IDLE) && !w_full_q;

    // With registered outputs the response waits one extra RESP cycle so that
    // bvalid still trails out.valid by exactly one cycle.
    assign s_axil_bvalid = (state_q == RESP) && (!OUT_REG || resp_arm_q);
    assign s_axil_bresp  = s_axil_bvalid ? {err_q, 1'b0} : 2'b00;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid  && s_axil_wready;
    assign b_hs  = s_axil_bvalid  && s_axil_bready;

    always_comb begin
        state_d     = state_q;
        aw_full_d   = aw_full_q;
        w_full_d    = w_full_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        resp_arm_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Address is stored already rebased so out.addr reads 0 in reset.
                if (aw_hs) begin
                    aw_full_d = 1'b1;
                    aw_addr_d = s_axil_awaddr - ADDR_BASE;
                end
                if (w_hs) begin
                    w_full_d = 1'b1;
                    w_data_d = s_axil_wdata;
                    err_d    = strb_bad;
                end
                if (aw_full_d && w_full_d) state_d = EMIT;
            end
            EMIT: begin
                state_d     = RESP;
                out_valid_d = !err_q;
                out_addr_d  = aw_addr_q;
                out_data_d  = w_data_q;
            end
            RESP: begin
                resp_arm_d = 1'b1;
                if (b_hs) begin
                    state_d    = IDLE;
                    aw_full_d  = 1'b0;
                    w_full_d   = 1'b0;
                    resp_arm_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= IDLE;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            resp_arm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            resp_arm_q  <= resp_arm_d;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            assign out.valid = out_valid_q;
            assign out.addr  = out_addr_q;
            assign out.data  = out_data_q;
        end else begin : g_out_comb
            assign out.valid = (state_q == EMIT) && !err_q;
            assign out.addr  = aw_addr_q;
            assign out.data  = w_data_q;
        end
    endgenerate
endmodule
